// File: rtl/mutton_bill_accum.sv
// Order-billing stage: prices 3-bit item codes, accumulates total/count, emits one held bill per checkout.
// Optional feature: define BILL_DISCOUNT_EN to subtract DISC_AMOUNT from totals at/above DISC_THRESH.
module mutton_bill_accum #(
    parameter int TOTAL_W     = 16,
    parameter int MAX_ITEMS   = 15,
    parameter int CNT_W       = 4,
    parameter int DISC_THRESH = 2000,
    parameter int DISC_AMOUNT = 100
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               item_valid_i,
    output logic               item_ready_o,
    input  logic [2:0]         item_code_i,
    input  logic               checkout_i,
    output logic               bill_valid_o,
    input  logic               bill_ready_i,
    output logic [TOTAL_W-1:0] bill_total_o,
    output logic [CNT_W-1:0]   bill_items_o,
    output logic               bill_err_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0]   MAX_CNT  = CNT_W'(MAX_ITEMS);
    localparam logic [TOTAL_W-1:0] DISC_THR = TOTAL_W'(DISC_THRESH);
    localparam logic [TOTAL_W-1:0] DISC_AMT = TOTAL_W'(DISC_AMOUNT);
`ifdef BILL_DISCOUNT_EN
    localparam bit DISC_EN = 1'b1;
`else
    localparam bit DISC_EN = 1'b0;
`endif

    state_e             state_q, state_d;
    logic [TOTAL_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic               xfer;
    logic               priced;
    logic [TOTAL_W:0]   price;
    logic [TOTAL_W:0]   sum;
    logic [TOTAL_W-1:0] total_rep;

    assign item_ready_o = (state_q != REPORT) && (cnt_q < MAX_CNT);
    assign xfer         = item_valid_i && item_ready_o;

    always_comb begin
        price  = '0;
        priced = 1'b0;
        unique0 case (item_code_i)
            3'b000: begin price = (TOTAL_W+1)'(1000); priced = 1'b1; end
            3'b101: begin price = (TOTAL_W+1)'(600);  priced = 1'b1; end
            3'b110: begin price = (TOTAL_W+1)'(200);  priced = 1'b1; end
            3'b111: begin price = (TOTAL_W+1)'(100);  priced = 1'b1; end
        endcase
    end

    // One extra bit catches overflow so the accumulator can pin at all-ones.
    assign sum = {1'b0, acc_q} + price;

    always_comb begin
        if (DISC_EN && (acc_q >= DISC_THR)) begin
            total_rep = acc_q - DISC_AMT;
        end else begin
            total_rep = acc_q;
        end
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        bill_valid_o = 1'b0;
        bill_total_o = '0;
        bill_items_o = '0;
        bill_err_o   = 1'b0;

        if (xfer) begin
            if (priced) begin
                cnt_d = cnt_q + 1'b1;
                if (sum[TOTAL_W]) begin
                    acc_d = '1;
                    err_d = 1'b1;
                end else begin
                    acc_d = sum[TOTAL_W-1:0];
                end
            end else begin
                err_d = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d = checkout_i ? REPORT : ACCUM;
                end
            end
            ACCUM: begin
                if (checkout_i) begin
                    state_d = REPORT;
                end
            end
            REPORT: begin
                bill_valid_o = 1'b1;
                bill_total_o = total_rep;
                bill_items_o = cnt_q;
                bill_err_o   = err_q;
                if (bill_ready_i) begin
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

endmodule

// File: tb/tb_mutton_bill_accum.sv
// Scoreboard bench for mutton_bill_accum: a 16-bit and a 12-bit instance share stimulus;
// expected bills come from an order-level model (sum of prices, clipped to the width).
module tb_mutton_bill_accum;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, item_valid, checkout, bill_ready;
    logic [2:0]  item_code;
    logic        item_ready_a, bill_valid_a, bill_err_a;
    logic [15:0] bill_total_a;
    logic [3:0]  bill_items_a;
    logic        item_ready_b, bill_valid_b, bill_err_b;
    logic [11:0] bill_total_b;
    logic [3:0]  bill_items_b;

    mutton_bill_accum u_dut_a (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .item_valid_i (item_valid),
        .item_ready_o (item_ready_a),
        .item_code_i  (item_code),
        .checkout_i   (checkout),
        .bill_valid_o (bill_valid_a),
        .bill_ready_i (bill_ready),
        .bill_total_o (bill_total_a),
        .bill_items_o (bill_items_a),
        .bill_err_o   (bill_err_a)
    );

    mutton_bill_accum #(.TOTAL_W(12)) u_dut_b (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .item_valid_i (item_valid),
        .item_ready_o (item_ready_b),
        .item_code_i  (item_code),
        .checkout_i   (checkout),
        .bill_valid_o (bill_valid_b),
        .bill_ready_i (bill_ready),
        .bill_total_o (bill_total_b),
        .bill_items_o (bill_items_b),
        .bill_err_o   (bill_err_b)
    );

    typedef struct {
        int total_a;
        int total_b;
        int items;
        int err_a;
        int err_b;
    } bill_t;

    bill_t exp_q[$];
    int    checks = 0;
    int    passes = 0;

    // Order-level model state
    int m_sum   = 0;
    int m_cnt   = 0;
    bit m_unk   = 0;
    bit m_open  = 0;
    bit m_rep   = 0;
    bit m_rst   = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    function automatic int price_of(input logic [2:0] c);
        case (c)
            3'b000:  return 1000;
            3'b101:  return 600;
            3'b110:  return 200;
            3'b111:  return 100;
            default: return -1;
        endcase
    endfunction

    function automatic int disc(input int t);
`ifdef BILL_DISCOUNT_EN
        if (t >= 2000) return t - 100;
`endif
        return t;
    endfunction

    function automatic bill_t make_bill();
        bill_t b;
        int mx_a = (1 << 16) - 1;
        int mx_b = (1 << 12) - 1;
        b.items   = m_cnt;
        b.total_a = disc((m_sum > mx_a) ? mx_a : m_sum);
        b.total_b = disc((m_sum > mx_b) ? mx_b : m_sum);
        b.err_a   = (m_unk || m_sum > mx_a) ? 1 : 0;
        b.err_b   = (m_unk || m_sum > mx_b) ? 1 : 0;
        return b;
    endfunction

    task automatic clear_order();
        m_sum = 0; m_cnt = 0; m_unk = 0; m_open = 0; m_rep = 0;
    endtask

    // One clock of stimulus; called just after a posedge.
    task automatic step(input bit rn, input bit v, input logic [2:0] c, input bit co, input bit br);
        bit mready;
        int p;
        rst_n = rn; item_valid = v; item_code = c; checkout = co; bill_ready = br;
        mready = !m_rep && (m_cnt < 15);
        @(negedge clk);
        chk("item_ready_a", int'(item_ready_a), int'(mready));
        chk("item_ready_b", int'(item_ready_b), int'(mready));
        chk("bill_valid_a", int'(bill_valid_a), int'(m_rep));
        chk("bill_valid_b", int'(bill_valid_b), int'(m_rep));
        if (m_rst) begin
            chk("reset_total_a", int'(bill_total_a), 0);
            chk("reset_total_b", int'(bill_total_b), 0);
        end
        @(posedge clk);
        if (!rn) begin
            clear_order();
            exp_q.delete();
            m_rst = 1;
        end else begin
            m_rst = 0;
            if (m_rep) begin
                if (br) clear_order();
            end else begin
                if (v && mready) begin
                    p = price_of(c);
                    if (p < 0) m_unk = 1;
                    else begin
                        m_sum += p;
                        m_cnt++;
                    end
                    m_open = 1;
                end
                if (co && m_open) begin
                    exp_q.push_back(make_bill());
                    m_rep = 1;
                end
            end
        end
        #1;
    endtask

    // Monitor: compare every presented bill against the head of the scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (bill_valid_a === 1'b1 || bill_valid_b === 1'b1) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    $display("FAIL unexpected_bill: got total %0d, expected no bill", bill_total_a);
                end else begin
                    chk("bill_total_a", int'(bill_total_a), exp_q[0].total_a);
                    chk("bill_total_b", int'(bill_total_b), exp_q[0].total_b);
                    chk("bill_items_a", int'(bill_items_a), exp_q[0].items);
                    chk("bill_items_b", int'(bill_items_b), exp_q[0].items);
                    chk("bill_err_a",   int'(bill_err_a),   exp_q[0].err_a);
                    chk("bill_err_b",   int'(bill_err_b),   exp_q[0].err_b);
                    if (bill_ready) void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic [2:0] codes4 [4];
        rst_n = 1'b0; item_valid = 1'b1; item_code = 3'b000; checkout = 1'b0; bill_ready = 1'b0;
        @(posedge clk);
        #1;
        m_rst = 1;
        step(0, 1, 3'b000, 0, 0);
        step(0, 1, 3'b000, 0, 0);

        codes4[0] = 3'b000; codes4[1] = 3'b101; codes4[2] = 3'b110; codes4[3] = 3'b111;
        for (int i = 0; i < 4; i++) step(1, 1, codes4[i], 0, 0);
        step(1, 0, 3'b000, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 3'b000, 0, 0);
        step(1, 0, 3'b000, 0, 1);
        step(1, 0, 3'b000, 0, 0);

        step(1, 1, 3'b101, 0, 0);
        step(1, 1, 3'b011, 1, 0);
        step(1, 0, 3'b000, 0, 1);
        step(1, 0, 3'b000, 1, 0);
        step(1, 0, 3'b000, 0, 0);

        for (int i = 0; i < 16; i++) step(1, 1, 3'b000, 0, 0);
        step(1, 0, 3'b000, 1, 0);
        step(1, 1, 3'b000, 0, 1);
        step(1, 0, 3'b000, 0, 0);

        step(1, 1, 3'b000, 0, 0);
        step(1, 1, 3'b000, 0, 0);
        step(1, 0, 3'b000, 1, 0);
        step(1, 0, 3'b000, 0, 1);

        step(1, 1, 3'b010, 1, 0);
        step(1, 0, 3'b000, 0, 1);

        step(1, 1, 3'b111, 1, 0);
        step(0, 0, 3'b000, 0, 0);
        step(1, 1, 3'b110, 0, 0);
        step(1, 0, 3'b000, 1, 0);
        step(1, 0, 3'b000, 0, 1);

        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 199) != 0),
                 $urandom_range(0, 3) != 0,
                 3'($urandom_range(0, 7)),
                 $urandom_range(0, 6) == 0,
                 $urandom_range(0, 2) != 0);
        end

        for (int i = 0; i < 4; i++) step(1, 0, 3'b000, 0, 1);
        chk("bills_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
